// File: rtl/load_align_unit.sv
// Multi-cycle RV32I load path: one word-aligned read on a req/gnt/rvalid port,
// then lane extraction and sign/zero extension of the addressed byte/half/word.
module load_align_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_start,
   input  logic [31:0] ld_addr,
   input  logic [1:0]  LdStrSrc,
   input  logic        ld_unsigned,
   output logic        ld_busy,
   output logic        ld_done,
   output logic        ld_err,
   output logic [31:0] ld_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [1:0]         off_q, off_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [31:0]        data_q, data_d;
   logic               req_ok;

   function automatic logic is_legal(input logic [1:0] off, input logic [1:0] size);
      logic ok;
      ok = 1'b1;
      if (size == 2'b11)                      ok = 1'b0;
      else if (size == SZ_HALF && off[0])     ok = 1'b0;
      else if (size == SZ_WORD && off != 2'b00) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [31:0] align_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{24{b[7]  & ~uns}}, b};
         SZ_HALF: r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   assign req_ok = is_legal(ld_addr[1:0], LdStrSrc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         off_q      <= 2'b00;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         mem_addr_q <= 32'h0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         data_q     <= 32'h0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         mem_addr_q <= mem_addr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (ld_start) state_d = req_ok ? S_REQ : S_DONE;
         S_REQ:  if (mem_gnt) state_d = S_WAIT;
         S_WAIT: if (mem_rvalid || cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Capture, timeout counting and result registration; rvalid beats timeout.
   always_comb begin
      off_d      = off_q;
      size_d     = size_q;
      uns_d      = uns_q;
      mem_addr_d = mem_addr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      data_d     = data_q;
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               off_d      = ld_addr[1:0];
               size_d     = LdStrSrc;
               uns_d      = ld_unsigned;
               mem_addr_d = {ld_addr[31:2], 2'b00};
               if (!req_ok) begin
                  err_d  = 1'b1;
                  data_d = 32'h0;
               end
            end
         end
         S_REQ: if (mem_gnt) cnt_d = '0;
         S_WAIT: begin
            if (mem_rvalid) begin
               err_d  = 1'b0;
               data_d = align_extend(mem_rdata, off_q, size_q, uns_q);
            end else if (cnt_q == CNT_LAST) begin
               err_d  = 1'b1;
               data_d = 32'h0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_req  = (state_q == S_REQ);
      ld_busy  = (state_q != S_IDLE);
      ld_done  = (state_q == S_DONE);
      ld_err   = err_q & (state_q == S_DONE);
      mem_addr = mem_addr_q;
      ld_data  = data_q;
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized and directed bench for load_align_unit; two instances share stimulus,
// one with the default timeout and one with a 4-cycle timeout.
module tb_load_align_unit;

   localparam int TO_B = 4;
   localparam int TO_A = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_start;
   logic [31:0] ld_addr;
   logic [1:0]  ld_src;
   logic        ld_unsigned;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   logic        a_busy, a_done, a_err, a_req;
   logic [31:0] a_data, a_addr;
   logic        b_busy, b_done, b_err, b_req;
   logic [31:0] b_data, b_addr;

   logic        use_b;
   logic        s_busy, s_done, s_err, s_req;
   logic [31:0] s_data, s_addr;

   int n_cmp = 0;
   int n_bad = 0;

   load_align_unit dut_a (
      .clk(clk), .reset(reset), .ld_start(ld_start), .ld_addr(ld_addr), .LdStrSrc(ld_src),
      .ld_unsigned(ld_unsigned), .ld_busy(a_busy), .ld_done(a_done), .ld_err(a_err),
      .ld_data(a_data), .mem_req(a_req), .mem_addr(a_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

   load_align_unit #(.TIMEOUT_CYCLES(TO_B), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .ld_start(ld_start), .ld_addr(ld_addr), .LdStrSrc(ld_src),
      .ld_unsigned(ld_unsigned), .ld_busy(b_busy), .ld_done(b_done), .ld_err(b_err),
      .ld_data(b_data), .mem_req(b_req), .mem_addr(b_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

   assign s_busy = use_b ? b_busy : a_busy;
   assign s_done = use_b ? b_done : a_done;
   assign s_err  = use_b ? b_err  : a_err;
   assign s_req  = use_b ? b_req  : a_req;
   assign s_data = use_b ? b_data : a_data;
   assign s_addr = use_b ? b_addr : a_addr;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the little-endian word.
   function automatic logic [31:0] model(input logic [31:0] addr, input logic [1:0] sz,
                                         input logic uns, input logic [31:0] rdata,
                                         output bit legal);
      int off;
      longint unsigned r;
      longint v;
      off   = int'(addr % 4);
      legal = !(sz == 2'd3 || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0));
      r     = longint'(rdata);
      v     = 0;
      if (sz == 2'd0) begin
         v = longint'((r >> (8 * off)) % 256);
         if (!uns && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'((r >> (8 * off)) % 65536);
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(r);
      end
      return legal ? 32'(v) : 32'h0;
   endfunction

   task automatic settle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ld_start = 1'b0;
         if (!a_busy && !b_busy) begin
            ok = 1'b1;
            break;
         end
         mem_gnt    = 1'b1;
         mem_rvalid = 1'b1;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      chk("settle_idle", 32'(ok), 32'd1);
   endtask

   // gd: REQ cycles before gnt; rd: cycles from gnt to rvalid (1 = first WAIT cycle).
   task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rdata, input int gd,
                           input int rd, input bit sel_b);
      bit          legal, timeout, req_ok, busy_ok, addr_ok;
      logic [31:0] exp_d, got_d, got_e, held_d;
      int          to, exp_done, done_c, n_done;
      use_b    = sel_b;
      exp_d    = model(addr, sz, uns, rdata, legal);
      to       = sel_b ? TO_B : TO_A;
      timeout  = legal && (rd > to);
      if (!legal)       exp_done = 1;
      else if (timeout) exp_done = 2 + gd + to;
      else              exp_done = 2 + gd + rd;
      if (timeout) exp_d = 32'h0;
      done_c = -1; n_done = 0; req_ok = 1; busy_ok = 1; addr_ok = 1;
      got_d = 32'h0; got_e = 32'h0; held_d = 32'h0;
      @(negedge clk);
      ld_start = 1'b1; ld_addr = addr; ld_src = sz; ld_unsigned = uns;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      for (int c = 1; c <= exp_done + 2; c++) begin
         @(negedge clk);
         ld_start = 1'b0; ld_addr = $urandom; ld_src = 2'($urandom); ld_unsigned = 1'($urandom);
         if (s_req !== (legal && c <= 1 + gd)) req_ok = 0;
         if (s_req === 1'b1 && s_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
         if (s_busy !== (c <= exp_done)) busy_ok = 0;
         if (s_done === 1'b1) begin
            n_done++;
            if (done_c < 0) begin
               done_c = c; got_d = s_data; got_e = 32'(s_err);
            end
         end
         held_d     = s_data;
         mem_gnt    = legal && (c == 1 + gd);
         mem_rvalid = legal && (c == 1 + gd + rd);
         mem_rdata  = (c == 1 + gd + rd) ? rdata : $urandom;
      end
      chk({tag, " done_cycle"}, 32'(done_c), 32'(exp_done));
      chk({tag, " done_count"}, 32'(n_done), 32'd1);
      chk({tag, " err"}, got_e, 32'(!legal || timeout));
      chk({tag, " data"}, got_d, exp_d);
      chk({tag, " data_held"}, held_d, exp_d);
      chk({tag, " req_window"}, 32'(req_ok), 32'd1);
      chk({tag, " mem_addr"}, 32'(addr_ok), 32'd1);
      chk({tag, " busy"}, 32'(busy_ok), 32'd1);
      settle();
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  sz;
      logic        uns;
   } req_t;

   task automatic back_to_back(input int n);
      req_t        pend[$];
      logic [31:0] expq[$];
      req_t        q, cur;
      logic [31:0] r;
      bit          lg, prev_gnt;
      int          nd, bad_t;
      nd = 0; bad_t = 0; prev_gnt = 1'b0; use_b = 1'b0;
      for (int c = 0; c <= 4 * n + 3; c++) begin
         @(negedge clk);
         if (a_done === 1'b1) begin
            nd++;
            if (c % 4 != 3) bad_t++;
            if (expq.size() > 0) chk("b2b data", a_data, expq.pop_front());
            else bad_t++;
         end
         mem_rvalid = prev_gnt;
         mem_rdata  = $urandom;
         if (prev_gnt && pend.size() > 0) begin
            r = $urandom;
            mem_rdata = r;
            q = pend.pop_front();
            expq.push_back(model(q.addr, q.sz, q.uns, r, lg));
         end
         mem_gnt  = a_req;
         prev_gnt = a_req;
         cur.sz   = 2'($urandom_range(0, 2));
         cur.addr = $urandom;
         cur.uns  = 1'($urandom);
         if (cur.sz == 2'd1) cur.addr[0] = 1'b0;
         if (cur.sz == 2'd2) cur.addr[1:0] = 2'b00;
         ld_start = (c < 4 * n); ld_addr = cur.addr; ld_src = cur.sz; ld_unsigned = cur.uns;
         if (c < 4 * n && c % 4 == 0) pend.push_back(cur);
      end
      ld_start = 1'b0;
      chk("b2b count", 32'(nd), 32'(n));
      chk("b2b timing", 32'(bad_t), 32'd0);
      settle();
   endtask

   task automatic reset_mid_wait();
      int nd;
      nd = 0;
      @(negedge clk);
      ld_start = 1'b1; ld_addr = 32'h0000_3000; ld_src = 2'd2; ld_unsigned = 1'b0;
      @(negedge clk);
      ld_start = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("rst pre_busy", 32'(a_busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst busy", 32'(a_busy), 32'd0);
      chk("rst data", a_data, 32'h0);
      chk("rst addr", a_addr, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (a_done || b_done || a_busy || b_busy) nd++;
      end
      chk("rst late_rvalid", 32'(nd), 32'd0);
   endtask

   initial begin
      bit          lg;
      logic [31:0] ra, rd_w;
      reset = 1'b1; ld_start = 1'b0; ld_addr = 32'h0; ld_src = 2'd0; ld_unsigned = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; use_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset busy", 32'(a_busy), 32'd0);
      chk("reset done", 32'(a_done), 32'd0);
      chk("reset err", 32'(a_err), 32'd0);
      chk("reset req", 32'(a_req), 32'd0);
      chk("reset data", a_data, 32'h0);
      chk("reset addr", a_addr, 32'h0);
      chk("reset b_busy", 32'(b_busy), 32'd0);
      reset = 1'b0;

      run_load("lb_signed", 32'h0000_1003, 2'd0, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("lbu", 32'h0000_1003, 2'd0, 1'b1, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("lh_hi", 32'h0000_1002, 2'd1, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("lh_lo", 32'h0000_1000, 2'd1, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("mis_half", 32'h0000_1001, 2'd1, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("mis_word", 32'h0000_1002, 2'd2, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("bad_size", 32'h0000_1000, 2'd3, 1'b0, 32'h80F1_7F22, 0, 1, 1'b0);
      run_load("stall", 32'h0000_2000, 2'd2, 1'b0, 32'hDEAD_BEEF, 4, 6, 1'b0);
      run_load("timeout", 32'h0000_2004, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 1000, 1'b1);
      run_load("rv_wins", 32'h0000_2004, 2'd2, 1'b0, 32'hCAFE_F00D, 1, 4, 1'b1);

      for (int i = 0; i < 30; i++) begin
         ra   = $urandom;
         rd_w = $urandom;
         run_load("rand", ra, 2'($urandom), 1'($urandom), rd_w,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0);
      end
      rd_w = model(32'h3, 2'd0, 1'b0, 32'hFF00_0000, lg);
      chk("model_sanity", rd_w, 32'hFFFF_FFFF);

      reset_mid_wait();
      back_to_back(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
